// File: rtl/serial_pair_adder_pkg.sv
// Shared definitions for the serial pair adder: FSM states, slice width and
// the single-bit full-adder cell used to build the 2-bit slice.
package serial_pair_adder_pkg;

  localparam int SLICE_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
    full_add = {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
  endfunction

endpackage

// File: rtl/serial_pair_adder_add2_slice.sv
// Combinational 2-bit ripple adder made of two full-adder cells.
module add2_slice
  import serial_pair_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [1:0] fa0_s;
  logic [1:0] fa1_s;

  // Ripple the carry from bit 0 into bit 1.
  always_comb begin
    fa0_s = full_add(a[0], b[0], cin);
    fa1_s = full_add(a[1], b[1], fa0_s[1]);
    sum   = {fa1_s[0], fa0_s[0]};
    cout  = fa1_s[1];
  end

endmodule

// File: rtl/serial_pair_adder.sv
// Serial WIDTH-bit adder: processes operands 2 bits per cycle, LSB first,
// through a single 2-bit slice, with valid/ready handshakes on both sides.
// Optional feature macro: OVERFLOW_FLAG_EN adds the out_ovf port carrying the
// two's-complement overflow of the result.
module serial_pair_adder
  import serial_pair_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
`ifdef OVERFLOW_FLAG_EN
  output logic             out_ovf,
`endif
  output logic             busy
);

  localparam int BEATS = WIDTH / SLICE_W;
  localparam int CNT_W = $clog2(BEATS) + 1;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t LAST_BEAT = cnt_t'(BEATS - 1);
  localparam cnt_t CNT_ONE   = cnt_t'(1);

  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("serial_pair_adder: WIDTH must be even and >= 2");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  cnt_t               cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_sum_q, out_sum_d;
  logic               out_cout_q, out_cout_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
`ifdef OVERFLOW_FLAG_EN
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               out_ovf_q, out_ovf_d;
`endif

  logic [SLICE_W-1:0] slice_sum_s;
  logic               slice_cout_s;

  add2_slice u_slice (
    .a    (a_q[SLICE_W-1:0]),
    .b    (b_q[SLICE_W-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum_s),
    .cout (slice_cout_s)
  );

  // Operands are taken only in IDLE and never while reset is held.
  assign in_ready  = (state_q == IDLE) & rst_n;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
`ifdef OVERFLOW_FLAG_EN
  assign out_ovf   = out_ovf_q;
`endif

  // Next-state, datapath shifting and result capture.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    out_sum_d  = out_sum_q;
    out_cout_d = out_cout_q;
`ifdef OVERFLOW_FLAG_EN
    a_msb_d    = a_msb_q;
    b_msb_d    = b_msb_q;
    out_ovf_d  = out_ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          sum_d   = {WIDTH{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          state_d = RUN;
`ifdef OVERFLOW_FLAG_EN
          a_msb_d = in_a[WIDTH-1];
          b_msb_d = in_b[WIDTH-1];
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // New slice bits enter at the top so after all beats bit 0 is at the bottom.
        a_d     = a_q >> SLICE_W;
        b_d     = b_q >> SLICE_W;
        sum_d   = (sum_q >> SLICE_W) | (WIDTH'(slice_sum_s) << (WIDTH - SLICE_W));
        carry_d = slice_cout_s;
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == LAST_BEAT) begin
          state_d    = DONE;
          out_sum_d  = sum_d;
          out_cout_d = slice_cout_s;
`ifdef OVERFLOW_FLAG_EN
          out_ovf_d  = (a_msb_q == b_msb_q) & (slice_sum_s[SLICE_W-1] != a_msb_q);
`endif
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      sum_q       <= {WIDTH{1'b0}};
      carry_q     <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      out_sum_q   <= {WIDTH{1'b0}};
      out_cout_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      out_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef OVERFLOW_FLAG_EN
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      out_ovf_q   <= out_ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_pair_adder.sv
// Scoreboard bench for serial_pair_adder (WIDTH=8): accepted operands push a
// reference result, an independent monitor pops and compares on each output
// handshake and watches latency, stability under backpressure and handshakes.
module tb_serial_pair_adder;

  localparam int WIDTH = 8;
  localparam int BEATS = WIDTH / 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;
`ifdef OVERFLOW_FLAG_EN
  logic             out_ovf;
`endif

  serial_pair_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
`ifdef OVERFLOW_FLAG_EN
    .out_ovf   (out_ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   b2b_mode = 1'b0;
  bit   have_hs = 1'b0;
  int   last_hs_cyc = 0;

  logic             prev_valid = 1'b0;
  logic             prev_ready = 1'b0;
  logic             prev_rst = 1'b0;
  logic [WIDTH-1:0] prev_sum = '0;
  logic             prev_cout = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle index, advanced on each rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: every accepted operand pair yields its exact sum.
  always @(negedge clk) begin : accept_proc
    exp_t e;
    logic [WIDTH:0] full;
    if (rst_n && in_valid && in_ready) begin
      full = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, in_cin};
      e.sum = full[WIDTH-1:0];
      e.cout = full[WIDTH];
      e.ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (e.sum[WIDTH-1] != in_a[WIDTH-1]);
      e.acc_cyc = cyc;
      sb_q.push_back(e);
      if (b2b_mode && have_hs) chk("b2b_accept_gap", cyc - last_hs_cyc, 1);
    end
  end

  // Output monitor: result compare, latency, backpressure stability.
  always @(negedge clk) begin : monitor_proc
    exp_t e;
    if (rst_n && prev_rst) begin
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_sum", out_sum, prev_sum);
        chk("hold_cout", out_cout, prev_cout);
      end else if (prev_valid && prev_ready) begin
        chk("valid_drop_after_hs", out_valid, 0);
        chk("in_ready_after_hs", in_ready, 1);
      end
    end
    if (rst_n && out_valid) begin
      chk("in_ready_low_in_done", in_ready, 0);
      chk("busy_in_done", busy, 1);
      if (!prev_valid || !prev_rst) begin
        if (sb_q.size() == 0) chk("latency_sb_nonempty", sb_q.size(), 1);
        else chk("latency", cyc - sb_q[0].acc_cyc, BEATS + 1);
      end
      if (out_ready) begin
        if (sb_q.size() == 0) begin
          chk("result_sb_nonempty", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          chk("sum", out_sum, e.sum);
          chk("cout", out_cout, e.cout);
`ifdef OVERFLOW_FLAG_EN
          chk("ovf", out_ovf, e.ovf);
`endif
          last_hs_cyc = cyc;
          have_hs = 1'b1;
        end
      end
    end
    prev_valid <= out_valid;
    prev_ready <= out_ready;
    prev_rst   <= rst_n;
    prev_sum   <= out_sum;
    prev_cout  <= out_cout;
  end

  // One operation: present operands, wait for result, hold back-pressure for
  // 'hold' cycles (>=1) while driving ignored operands, then take the result.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input int hold);
    int t;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; out_ready = 1'b0;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    if (!out_valid) chk("result_timeout", out_valid, 1);
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Stimulus sequence.
  initial begin : stim_proc
    int t;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cout", out_cout, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Directed sums, including carry across all beats and the overflow cases.
    run_op(8'h5A, 8'h3C, 1'b0, 1);
    run_op(8'hFF, 8'h01, 1'b0, 1);
    run_op(8'hFF, 8'h00, 1'b1, 1);
    run_op(8'h7F, 8'h01, 1'b0, 1);
    run_op(8'h80, 8'h80, 1'b0, 1);
    run_op(8'h10, 8'h20, 1'b0, 1);
    // Three cycles of back-pressure with ignored operands.
    run_op(8'hC3, 8'h5E, 1'b1, 3);

    // Reset during RUN beat 2 discards the operation.
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 8'hA5; in_b = 8'h96; in_cin = 1'b1;
    @(negedge clk);
    chk("rst_test_accept", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_run_busy", busy, 1);
    chk("in_ready_during_rst", in_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("after_rst_out_valid", out_valid, 0);
    chk("after_rst_busy", busy, 0);
    chk("after_rst_out_sum", out_sum, 0);
    chk("after_rst_in_ready", in_ready, 1);
    sb_q.delete();

    // Back-to-back operations with in_valid held high and no back-pressure.
    have_hs = 1'b0;
    b2b_mode = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; out_ready = 1'b1;
    in_a = WIDTH'($urandom); in_b = WIDTH'($urandom); in_cin = 1'($urandom_range(0, 1));
    for (int n = 0; n < 4; n++) begin
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin @(negedge clk); t++; end
      if (!in_ready) chk("b2b_accept_timeout", in_ready, 1);
      @(posedge clk); #1;
      in_a = WIDTH'($urandom); in_b = WIDTH'($urandom); in_cin = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    t = 0;
    while (sb_q.size() != 0 && t < 50) begin @(negedge clk); t++; end
    chk("b2b_drain", sb_q.size(), 0);
    @(posedge clk); #1;
    b2b_mode = 1'b0; out_ready = 1'b0;

    // Randomized operands and back-pressure.
    for (int n = 0; n < 30; n++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)), $urandom_range(1, 4));
    end

    repeat (3) @(negedge clk);
    chk("sb_empty_end", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin : watchdog_proc
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
